// File: rtl/mem_bus_bridge_pkg.sv
// Shared types and helpers for the memory-side bus bridges.
// Holds the bridge state encoding, the transfer size codes and the strobe-to-size rule.
package mem_bus_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } bridge_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Irregular strobe patterns fall back to a full-word transfer; the strobes still qualify the bytes.
  function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
    logic [1:0] size;
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
      4'b0011, 4'b1100:                   size = SIZE_HALF;
      default:                            size = SIZE_WORD;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/mem_bus_bridge.sv
// Bridges a single-cycle memory-stage request onto a split address/data-phase SRAM-like bus,
// freezing the pipeline until the data phase completes or the watchdog aborts it.
module mem_bus_bridge
  import mem_bus_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        pipe_hold,
  output logic [31:0] mem_rdata,
  output logic        stall,
  output logic        bus_err,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  localparam bit              WD_EN    = (TIMEOUT_CYCLES > 0);
  localparam int              LAST_I   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);

  bridge_state_t    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata_q;
  logic             bus_err_q;

  logic             issue;
  logic             in_flight;
  logic             timeout_hit;

  assign issue       = (state_q == ST_IDLE) && mem_en;
  assign in_flight   = (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign timeout_hit = WD_EN && in_flight && (cnt_q == CNT_LAST);

  // The request fields are presented straight from the held memory-stage inputs.
  assign data_req   = issue || (state_q == ST_ADDR);
  assign stall      = data_req || (state_q == ST_DATA);
  assign data_wr    = |mem_wen;
  assign data_wstrb = mem_wen;
  assign data_wdata = mem_wdata;
  assign data_size  = data_wr ? wen_to_size(mem_wen) : SIZE_WORD;
  assign data_addr  = data_wr ? mem_addr : {mem_addr[31:2], 2'b00};

  assign mem_rdata  = rdata_q;
  assign bus_err    = bus_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      if (in_flight && WD_EN) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (mem_en) begin
            cnt_q <= '0;
            if (data_addr_ok && data_data_ok) begin
              rdata_q <= data_rdata;
              state_q <= ST_DONE;
            end else if (data_addr_ok) begin
              state_q <= ST_DATA;
            end else begin
              state_q <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          // A completing handshake wins over an abort landing in the same cycle.
          if (data_addr_ok && data_data_ok) begin
            rdata_q <= data_rdata;
            state_q <= ST_DONE;
          end else if (timeout_hit) begin
            rdata_q   <= '0;
            bus_err_q <= 1'b1;
            state_q   <= ST_DONE;
          end else if (data_addr_ok) begin
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (data_data_ok) begin
            rdata_q <= data_rdata;
            state_q <= ST_DONE;
          end else if (timeout_hit) begin
            rdata_q   <= '0;
            bus_err_q <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!pipe_hold) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Bench for mem_bus_bridge: directed scenarios plus randomized transactions against a
// transaction-level model of latency, handshake count, field encoding and returned data.
module tb_mem_bus_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        pipe_hold;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        bus_err;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int checks = 0;
  int errors = 0;

  mem_bus_bridge #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .pipe_hold(pipe_hold), .mem_rdata(mem_rdata), .stall(stall),
    .bus_err(bus_err), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  function automatic logic [1:0] ref_size(input logic [3:0] w);
    if (w == 4'b0000) return 2'd2;
    if ($countones(w) == 1) return 2'd0;
    if (w == 4'b0011 || w == 4'b1100) return 2'd1;
    return 2'd2;
  endfunction

  // One complete transaction: slave accepts the address a_dly cycles after issue and
  // returns data d_dly cycles after that; pipe_hold keeps DONE for 'hold' extra cycles.
  task automatic run_txn(input string nm, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int a_dly, input int d_dly, input int hold);
    int exp_stall, exp_req, nstall, nreq, k;
    bit fin, to;
    logic [31:0] exp_rd, exp_addr;
    logic [1:0] exp_sz;
    to        = (a_dly + d_dly) > TO;
    exp_stall = (to ? TO : a_dly + d_dly) + 1;
    exp_req   = ((a_dly > TO) ? TO : a_dly) + 1;
    exp_rd    = to ? 32'h0 : rd;
    exp_addr  = (wen == 4'b0000) ? {addr[31:2], 2'b00} : addr;
    exp_sz    = ref_size(wen);

    @(posedge clk); #1;
    mem_en = 1'b1; mem_wen = wen; mem_addr = addr; mem_wdata = wd;
    pipe_hold = (hold > 0);
    nstall = 0; nreq = 0; fin = 0; k = 0;
    while (!fin && k < 40) begin
      data_addr_ok = (k == a_dly);
      data_data_ok = (k == a_dly + d_dly);
      data_rdata   = (k == a_dly + d_dly) ? rd : $urandom;
      @(negedge clk);
      if (stall) begin
        nstall++;
        if (data_req) begin
          nreq++;
          checks++;
          if (data_addr !== exp_addr) begin errors++; $display("FAIL %s data_addr: got %h expected %h", nm, data_addr, exp_addr); end
          checks++;
          if (data_size !== exp_sz) begin errors++; $display("FAIL %s data_size: got %0d expected %0d", nm, data_size, exp_sz); end
          checks++;
          if (data_wr !== (wen != 4'b0000)) begin errors++; $display("FAIL %s data_wr: got %b expected %b", nm, data_wr, (wen != 4'b0000)); end
          checks++;
          if (data_wstrb !== wen) begin errors++; $display("FAIL %s data_wstrb: got %b expected %b", nm, data_wstrb, wen); end
          checks++;
          if (data_wdata !== wd) begin errors++; $display("FAIL %s data_wdata: got %h expected %h", nm, data_wdata, wd); end
        end
        @(posedge clk); #1;
        k++;
      end else begin
        fin = 1;
      end
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s completion: stall still high after %0d cycles, expected %0d", nm, k, exp_stall);
      mem_en = 1'b0; mem_wen = '0; pipe_hold = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
      return;
    end
    checks++;
    if (nstall != exp_stall) begin errors++; $display("FAIL %s stall_cycles: got %0d expected %0d", nm, nstall, exp_stall); end
    checks++;
    if (nreq != exp_req) begin errors++; $display("FAIL %s req_cycles: got %0d expected %0d", nm, nreq, exp_req); end

    for (int h = 0; h <= hold; h++) begin
      checks++;
      if (stall !== 1'b0 || data_req !== 1'b0) begin errors++; $display("FAIL %s done_idle_bus: stall=%b req=%b expected 0 0", nm, stall, data_req); end
      checks++;
      if (mem_rdata !== exp_rd) begin errors++; $display("FAIL %s mem_rdata: got %h expected %h (done cycle %0d)", nm, mem_rdata, exp_rd, h); end
      checks++;
      if (bus_err !== (to && h == 0)) begin errors++; $display("FAIL %s bus_err: got %b expected %b (done cycle %0d)", nm, bus_err, (to && h == 0), h); end
      @(posedge clk); #1;
      data_addr_ok = $urandom; data_data_ok = $urandom; data_rdata = $urandom;
      pipe_hold = (h + 1 < hold);
      if (h == hold) begin
        mem_en = 1'b0; mem_wen = '0; mem_addr = $urandom; mem_wdata = $urandom;
      end
      @(negedge clk);
    end
    checks++;
    if (stall !== 1'b0 || data_req !== 1'b0) begin errors++; $display("FAIL %s idle_bus: stall=%b req=%b expected 0 0", nm, stall, data_req); end
    checks++;
    if (mem_rdata !== exp_rd || bus_err !== 1'b0) begin errors++; $display("FAIL %s idle_hold: rdata=%h err=%b expected %h 0", nm, mem_rdata, bus_err, exp_rd); end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_en = 1'b0; mem_wen = '0; mem_addr = '0; mem_wdata = '0; pipe_hold = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_rdata !== 32'h0 || bus_err !== 1'b0) begin errors++; $display("FAIL reset_regs: rdata=%h err=%b expected 0 0", mem_rdata, bus_err); end
    checks++;
    if (data_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL reset_bus: req=%b stall=%b expected 0 0", data_req, stall); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (data_req !== 1'b0 || stall !== 1'b0 || mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_release: req=%b stall=%b rdata=%h expected 0 0 0", data_req, stall, mem_rdata); end
  endtask

  task automatic test_word_load();
    run_txn("word_load", 4'b0000, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1, 0);
    run_txn("word_load_unaligned", 4'b0000, 32'h0000_0107, 32'h0, 32'h1357_9BDF, 1, 2, 0);
  endtask

  task automatic test_byte_store();
    run_txn("byte_store", 4'b0100, 32'h0000_0203, 32'h5A5A_5A5A, 32'h0BAD_F00D, 3, 1, 0);
    run_txn("half_store", 4'b1100, 32'h0000_0412, 32'hA5A5_A5A5, 32'h0, 0, 2, 0);
    run_txn("odd_store", 4'b0110, 32'h0000_0511, 32'h1234_5678, 32'h0, 2, 0, 0);
  endtask

  task automatic test_same_cycle();
    run_txn("same_cycle", 4'b0000, 32'h0000_0600, 32'h0, 32'hCAFE_0001, 0, 0, 0);
  endtask

  task automatic test_pipe_hold();
    run_txn("pipe_hold", 4'b0000, 32'h0000_0700, 32'h0, 32'h7777_1234, 1, 1, 3);
  endtask

  task automatic test_timeout();
    run_txn("timeout_data", 4'b0000, 32'h0000_0300, 32'h0, 32'h1234_5678, 1, 100, 1);
    run_txn("timeout_addr", 4'b1111, 32'h0000_0304, 32'hFFFF_0000, 32'h8765_4321, 100, 0, 0);
    run_txn("edge_no_timeout", 4'b0000, 32'h0000_0308, 32'h0, 32'h0F0F_F0F0, 3, 5, 0);
    run_txn("after_timeout", 4'b0000, 32'h0000_030C, 32'h0, 32'hABCD_EF01, 0, 1, 0);
  endtask

  task automatic test_reset_in_data();
    @(posedge clk); #1;
    mem_en = 1'b1; mem_wen = '0; mem_addr = 32'h0000_0080; pipe_hold = 1'b0;
    data_addr_ok = 1'b1; data_data_ok = 1'b0; data_rdata = $urandom;
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || data_req !== 1'b0) begin errors++; $display("FAIL rst_in_data_pre: stall=%b req=%b expected 1 0", stall, data_req); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_en = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || data_req !== 1'b0 || mem_rdata !== 32'h0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL rst_in_data_post: stall=%b req=%b rdata=%h err=%b expected 0 0 0 0", stall, data_req, mem_rdata, bus_err);
    end
    run_txn("load_after_rst", 4'b0000, 32'h0000_0040, 32'h0, 32'h4040_4040, 1, 2, 0);
  endtask

  task automatic test_random();
    logic [3:0] w;
    for (int n = 0; n < 40; n++) begin
      w = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) w = 4'b0000;
      run_txn("random", w, $urandom, $urandom, $urandom,
              int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_same_cycle();
    test_pipe_hold();
    test_timeout();
    test_reset_in_data();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_bridge.md
Name: mem_bus_bridge

Overview:
- Sits directly downstream of the memory-stage access unit.
- Converts its single-cycle data-memory request (mem_en / mem_wen / mem_addr / mem_wdata) into a split-transaction SRAM-like bus: an address phase with addr_ok, and a data phase with data_ok.
- Stalls the pipeline until the access completes, then returns read data on mem_rdata.
- A watchdog terminates hung transactions with a bus error.

Parameters:
- TIMEOUT_CYCLES, 256: cycles allowed from request issue to data_ok before abort; 0 disables the watchdog.
- CNT_W, 9: width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mem_en  in  1  access request from memory stage; held stable while stall=1
- mem_wen  in  4  byte write strobes; 0 means load
- mem_addr  in  32  byte address
- mem_wdata  in  32  store data, already lane-replicated
- pipe_hold  in  1  downstream/global stall; pipeline cannot advance this cycle
- mem_rdata  out  32  registered read word to memory stage
- stall  out  1  request in flight; pipeline must freeze
- bus_err  out  1  one-cycle pulse in DONE when the transaction timed out
- data_req  out  1  bus address-phase valid
- data_wr  out  1  1 = write
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  32  bus address
- data_wstrb  out  4  byte strobes (copy of mem_wen)
- data_wdata  out  32  bus write data
- data_addr_ok  in  1  address phase accepted this cycle
- data_data_ok  in  1  data phase complete; read data valid
- data_rdata  in  32  read data

Behaviour:
- Reset: state IDLE, counter 0; mem_rdata, bus_err, data_req all 0.
- In-flight bus transactions are discarded on reset; the slave shares rst.
- States: IDLE, ADDR, DATA, DONE.
- Address/size:
  - Loads: data_addr = {mem_addr[31:2], 2'b00}, data_size = 2 (full word; byte/half extraction is done upstream from mem_rdata).
  - Stores: data_addr = mem_addr; data_size from mem_wen: 4'b1111 → 2; 4'b0011 or 4'b1100 → 1; one-hot → 0; any other pattern → 2.
- data_wr = |mem_wen. data_wdata = mem_wdata. These fields are driven combinationally from the held inputs.
- IDLE:
  - mem_en=0: stall=0, data_req=0.
  - mem_en=1: data_req=1, stall=1.
    - addr_ok=0 → ADDR.
    - addr_ok=1 with data_ok=0 → DATA.
    - addr_ok=1 with data_ok=1 → capture rdata, go DONE.
- ADDR: data_req=1, stall=1.
  - addr_ok=1 → DATA, or → DONE if data_ok is also 1 (capture rdata).
- DATA: data_req=0, stall=1.
  - data_ok=1 → capture data_rdata into mem_rdata (writes capture too, value unused), go DONE.
- DONE: stall=0, data_req=0; mem_rdata is stable.
  - pipe_hold=1 → stay in DONE and do not reissue, even though mem_en is still 1.
  - pipe_hold=0 → IDLE. The next request is seen the following cycle.
- Minimum latency: a request is visible 1 cycle with stall=1, then DONE; a load costs 2 cycles total.
- Watchdog:
  - Counter clears on IDLE→(ADDR|DATA|DONE) and increments each cycle in ADDR or DATA.
  - When count reaches TIMEOUT_CYCLES-1 without completion, go DONE with mem_rdata=0 and bus_err=1 for the first DONE cycle only.
  - data_req drops and any late data_ok is ignored.
- data_ok while IDLE or DONE: ignored.
- addr_ok while data_req=0: ignored.

Decomposition:
- Shared package: state enum (bridge_state_t), SIZE_BYTE/HALF/WORD constants, and the wen→size function (shared with a future instruction-side bridge).
- No sub-module; the watchdog counter stays inline.

Test Plan:
- Word load at 0x100; addr_ok at cycle 0, data_ok at cycle 1 with rdata 0xDEADBEEF → data_addr=0x100, size=2, stall high 2 cycles, mem_rdata=0xDEADBEEF in DONE.
- Byte store mem_wen=4'b0100, addr 0x203, wdata 0x5A5A5A5A; addr_ok delayed 3 cycles → data_req held 4 cycles, data_wr=1, data_size=0, data_addr=0x203, data_wstrb=4'b0100.
- addr_ok and data_ok in the same cycle as the IDLE request → direct to DONE; exactly one data_req cycle.
- Load completes while pipe_hold=1 for 3 cycles → stays in DONE, no second data_req, mem_rdata stable; returns to IDLE when pipe_hold falls.
- TIMEOUT_CYCLES=8, slave never asserts data_ok → bus_err pulses once, mem_rdata=0, stall drops; a late data_ok is ignored.
- rst asserted while in DATA → next cycle IDLE, stall=0, data_req=0; a following load to 0x40 completes normally.
